// File: rtl/alu_result_register_pkg.sv
// alu_result_register_pkg: shared widths, depth and ALU function-code encoding
package alu_result_register_pkg;
  localparam int ALU_DATA_W = 8;
  localparam int ALU_OPND_W = ALU_DATA_W / 2;
  localparam int RESULT_DEPTH = 4;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_OR_RED = 2'b01,
    ALU_AND_RED = 2'b10,
    ALU_CONCAT = 2'b11
  } alu_op_e;
endpackage

// File: rtl/alu_result_register_fifo.sv
// result_fifo: show-ahead FIFO of captured ALU results with occupancy count
module result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_din,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_dout,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  // pointers wrap naturally at DEPTH (power of 2); simultaneous push/pop keeps count
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  // storage is not reset; only the pointers define what is queued
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end
  assign o_empty = (r_count == '0);
  assign o_full = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_dout = o_empty ? '0 : r_mem[r_rd];
endmodule

// File: rtl/alu_result_register.sv
// alu_result_register: accumulates ALU results, feeds B operand back, queues results
module alu_result_register
  import alu_result_register_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OPND_W = ALU_OPND_W,
  parameter int DEPTH = RESULT_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      alu_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   clear,
  output logic [OPND_W-1:0]      b_feedback,
  output logic [DATA_W-1:0]      acc_out,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   dropped
);
  logic [DATA_W-1:0] r_acc;
  logic r_dropped;
  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_pop;
  assign in_ready = ~w_full;
  assign out_valid = ~w_empty;
  assign w_accept = in_valid & in_ready;
  assign w_pop = out_valid & out_ready;
  // accumulator: clear wins over a same-cycle capture
  always_ff @(posedge clock) begin
    if (reset || clear) r_acc <= '0;
    else if (w_accept) r_acc <= alu_in;
  end
  // sticky flag for a result offered while the queue was full
  always_ff @(posedge clock) begin
    if (reset) r_dropped <= 1'b0;
    else if (in_valid && w_full) r_dropped <= 1'b1;
  end
  result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_accept),
    .i_din   (alu_in),
    .i_pop   (w_pop),
    .o_dout  (out_data),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign acc_out = r_acc;
  assign b_feedback = r_acc[OPND_W-1:0];
  assign dropped = r_dropped;
endmodule

// File: tb/tb_alu_result_register.sv
// tb_alu_result_register: directed and random checks against a queue-based model
module tb_alu_result_register;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic reset;
  logic [7:0] alu_in;
  logic in_valid;
  logic in_ready;
  logic clear;
  logic [3:0] b_feedback;
  logic [7:0] acc_out;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [2:0] count;
  logic dropped;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] q[$];
  logic [7:0] m_acc;
  bit m_drop;
  always #5 clock = ~clock;
  alu_result_register dut (
    .clock      (clock),
    .reset      (reset),
    .alu_in     (alu_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clear      (clear),
    .b_feedback (b_feedback),
    .acc_out    (acc_out),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .dropped    (dropped)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    check("acc_out", 32'(acc_out), 32'(m_acc));
    check("b_feedback", 32'(b_feedback), 32'(m_acc[3:0]));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("out_data", 32'(out_data), q.size() != 0 ? 32'(q[0]) : 32'h0);
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    check("dropped", 32'(dropped), 32'(m_drop));
  endtask
  task automatic step();
    bit full, acc_ok, pop_ok;
    full = (q.size() == DEPTH);
    acc_ok = in_valid && !full;
    pop_ok = out_ready && q.size() != 0;
    @(posedge clock);
    #1;
    if (reset) begin
      q.delete();
      m_acc = 8'h00;
      m_drop = 1'b0;
    end else begin
      if (pop_ok) void'(q.pop_front());
      if (acc_ok) q.push_back(alu_in);
      if (clear) m_acc = 8'h00;
      else if (acc_ok) m_acc = alu_in;
      if (in_valid && full) m_drop = 1'b1;
    end
    check_all();
  endtask
  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
    in_valid = v;
    alu_in = d;
    out_ready = r;
    clear = c;
    step();
  endtask
  initial begin
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h01, 8'h02, 8'h03, 8'h04};
    m_acc = 8'h00;
    m_drop = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0;
    alu_in = 8'h00;
    out_ready = 1'b0;
    clear = 1'b0;
    step();
    step();
    reset = 1'b0;
    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    drive(1'b1, 8'h35, 1'b0, 1'b0);
    check("acc_35", 32'(acc_out), 32'h35);
    check("bfb_5", 32'(b_feedback), 32'h5);
    check("odata_35", 32'(out_data), 32'h35);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    check("full_count", 32'(count), 32'h4);
    check("full_ready", 32'(in_ready), 32'h0);
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    check("drop_set", 32'(dropped), 32'h1);
    check("drop_count", 32'(count), 32'h4);
    for (int i = 0; i < 4; i++) begin
      check("pop_seq", 32'(out_data), 32'(exp_seq[i]));
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drained", 32'(out_valid), 32'h0);
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    check("simul_count", 32'(count), 32'h2);
    check("simul_head", 32'(out_data), 32'h22);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0);
    drive(1'b1, 8'h7F, 1'b0, 1'b1);
    check("clr_acc", 32'(acc_out), 32'h0);
    check("clr_push", 32'(count), 32'h3);
    in_valid = 1'b1;
    reset = 1'b1;
    alu_in = 8'h99;
    step();
    reset = 1'b0;
    check("mid_rst_count", 32'(count), 32'h0);
    check("mid_rst_drop", 32'(dropped), 32'h0);
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive(1'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0), $urandom_range(0, 15) == 0);
    end
    reset = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_result_register.md
Name: alu_result_register

Overview:
- Downstream stage of the 4-bit ALU: captures each 8-bit ALU result into an accumulator register.
- Feeds the low nibble of that register back as the ALU's B operand.
- Queues every captured result in a small FIFO for the display/readout stage.
- Turns the combinational ALU into a sequential datapath clocked from a board key/clock.

Parameters:
- DATA_W, 8, width of ALU result and accumulator
- OPND_W, 4, width of B feedback operand (DATA_W/2)
- DEPTH, 4, result FIFO entries (power of 2, at least 2)

Ports:
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- alu_in  in  DATA_W  result from ALU
- in_valid  in  1  alu_in holds a result to capture
- in_ready  out  1  block can accept a result this cycle
- clear  in  1  synchronous accumulator clear
- b_feedback  out  OPND_W  acc[OPND_W-1:0], drives ALU B input
- acc_out  out  DATA_W  current accumulator value
- out_data  out  DATA_W  oldest queued result (show-ahead)
- out_valid  out  1  out_data is meaningful
- out_ready  in  1  consumer takes out_data this cycle
- count  out  $clog2(DEPTH)+1  entries queued
- dropped  out  1  sticky: a result was offered while the FIFO was full

Behaviour:
- Reset (synchronous, active-high; clock is the only clock):
  - acc=0, FIFO write and read pointers=0, count=0, dropped=0.
  - Outputs after reset: out_valid=0, out_data=0, in_ready=1, b_feedback=0.
  - Reset asserted mid-operation discards all queued entries; the FIFO RAM contents need not be cleared.
- Handshakes:
  - Accept: accept = in_valid & in_ready.
  - in_ready = (count != DEPTH). It is combinational from count and does not depend on out_ready, so there is no same-cycle pass-through when full.
  - Pop: pop = out_valid & out_ready.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] when count != 0, else 0.
- Accumulator:
  - On accept: acc <= alu_in.
  - clear=1 forces acc <= 0, and has priority over accept for acc only.
  - An accepted sample is still pushed to the FIFO when clear is also asserted.
  - Latency: accepted value appears on acc_out/b_feedback 1 cycle after the accept edge.
- FIFO:
  - On accept: mem[wr_ptr] <= alu_in and wr_ptr advances.
  - On pop: rd_ptr advances.
  - Pointers wrap modulo DEPTH.
  - Simultaneous accept and pop leaves count unchanged.
  - A pop while empty cannot occur (out_valid=0). A push while full cannot occur (in_ready=0).
  - A result written to an empty FIFO shows on out_data 1 cycle after the accept edge.
- Occupancy states, derived from count:
  - EMPTY (count=0): only accept is legal; goes to PARTIAL on accept.
  - PARTIAL: goes to FULL on accept without pop when count=DEPTH-1; goes to EMPTY on pop without accept when count=1; otherwise stays.
  - FULL (count=DEPTH): goes to PARTIAL on pop. An offered result is ignored and sets dropped<=1.
- dropped clears only on reset.
- Arithmetic: no arithmetic on data; values are stored verbatim. count width $clog2(DEPTH)+1 so DEPTH is representable.

Decomposition:
- Shared package:
  - DATA_W and OPND_W constants.
  - The ALU function-code encoding (00 add, 01 or-reduce, 10 and-reduce, 11 concat) for benches that drive the ALU in a loop.
- One sub-module: result_fifo (show-ahead, parameterised DATA_W/DEPTH, push/pop/count/full/empty).
- The accumulator, clear priority and dropped flag live in alu_result_register.

Test Plan:
- Reset, then idle 3 cycles -> acc_out=0, b_feedback=0, out_valid=0, count=0, in_ready=1, dropped=0.
- Accept alu_in=8'h35 once, out_ready=0 -> next cycle acc_out=8'h35, b_feedback=4'h5, out_valid=1, out_data=8'h35, count=1.
- Accept 8'h01, 8'h02, 8'h03, 8'h04 back-to-back with out_ready=0 -> count=4, in_ready=0. Offer 8'h05 -> dropped=1, count stays 4. Pop four with out_ready=1 -> out_data sequence 01,02,03,04, then out_valid=0.
- With count=2, accept 8'hAA and pop in the same cycle -> count stays 2 and the queue order is preserved. Wrap test: 10 accept/pop pairs -> pointer wrap shows no reordering.
- clear=1 together with accept of 8'h7F -> acc_out=0 next cycle, FIFO receives 8'h7F (count+1).
- Reset asserted with count=3 and in_valid=1 -> next cycle count=0, out_valid=0, acc_out=0, dropped=0, nothing captured.
